alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 141 ++++++++++++++
 tb/tb_alu_seq.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith/shift/compare ops plus an
// iterative restoring divider for DIVU/REMU, with a held result until consumed.
module alu_seq #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [3:0]      alu_control,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic            alu_zero_flag,
  output logic            alu_illegal
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_DIVU = 4'b1010;
  localparam logic [3:0] OP_REMU = 4'b1011;

  state_t          state_q, state_d;
  logic [XLEN-1:0] result_q;
  logic            illegal_q;
  logic [XLEN-1:0] quo_q, rem_q, div_q;
  logic            want_rem_q;
  logic [SHW-1:0]  cnt_q;

  logic [XLEN-1:0] fast_result;
  logic            fast_illegal;
  logic [SHW-1:0]  shamt;
  logic            is_div, accept, last_step;
  logic [XLEN:0]   shifted, trial;
  logic [XLEN-1:0] quo_nxt, rem_nxt;

  assign in_ready      = (state_q == IDLE);
  assign out_valid     = (state_q == DONE);
  assign alu_result    = result_q;
  assign alu_illegal   = illegal_q;
  assign alu_zero_flag = (result_q == '0);

  assign is_div    = (alu_control == OP_DIVU) || (alu_control == OP_REMU);
  assign accept    = in_valid && in_ready && !flush;
  assign last_step = (cnt_q == SHW'(XLEN - 1));

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    fast_result  = '0;
    fast_illegal = 1'b0;
    shamt        = operand_b[SHW-1:0];
    case (alu_control)
      OP_AND:  fast_result = operand_a & operand_b;
      OP_OR:   fast_result = operand_a | operand_b;
      OP_ADD:  fast_result = operand_a + operand_b;
      OP_XOR:  fast_result = operand_a ^ operand_b;
      OP_SLL:  fast_result = operand_a << shamt;
      OP_SRL:  fast_result = operand_a >> shamt;
      OP_SUB:  fast_result = operand_a - operand_b;
      OP_SRA:  fast_result = $signed(operand_a) >>> shamt;
      OP_SLT:  fast_result = XLEN'($signed(operand_a) < $signed(operand_b));
      OP_SLTU: fast_result = XLEN'(operand_a < operand_b);
      OP_DIVU, OP_REMU: fast_result = '0;
      default: fast_illegal = 1'b1;
    endcase
  end

  // One restoring step: shift the next dividend bit into the partial remainder
  // and keep the subtraction only when it does not borrow.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    trial   = shifted - {1'b0, div_q};
    rem_nxt = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
    quo_nxt = {quo_q[XLEN-2:0], ~trial[XLEN]};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = is_div ? BUSY : DONE;
      BUSY:    if (last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q   <= '0;
      illegal_q  <= 1'b0;
      quo_q      <= '0;
      rem_q      <= '0;
      div_q      <= '0;
      want_rem_q <= 1'b0;
      cnt_q      <= '0;
    end else if (flush) begin
      cnt_q <= '0;
    end else if (accept) begin
      if (is_div) begin
        quo_q      <= operand_a;
        rem_q      <= '0;
        div_q      <= operand_b;
        want_rem_q <= alu_control[0];
        cnt_q      <= '0;
      end else begin
        result_q  <= fast_result;
        illegal_q <= fast_illegal;
      end
    end else if (state_q == BUSY) begin
      quo_q <= quo_nxt;
      rem_q <= rem_nxt;
      cnt_q <= cnt_q + SHW'(1);
      if (last_step) begin
        result_q  <= want_rem_q ? rem_nxt : quo_nxt;
        illegal_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: two instances (XLEN=32 and XLEN=8) run the same
// directed + random set against an arithmetic reference model.
module tb_alu_seq;

  typedef struct {
    logic [63:0] result;
    logic        illegal;
    int          accept_cyc;
    int          latency;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;
  bit finished   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  for (genvar g = 0; g < 2; g++) begin : env
    localparam int W = (g == 0) ? 32 : 8;

    logic         rst_n, in_valid, in_ready, flush, out_valid, out_ready;
    logic         alu_zero_flag, alu_illegal;
    logic [W-1:0] operand_a, operand_b, alu_result;
    logic [3:0]   alu_control;
    bit           done_flag = 0;
    exp_t         sb_q[$];

    alu_seq #(.XLEN(W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .operand_a    (operand_a),
      .operand_b    (operand_b),
      .alu_control  (alu_control),
      .flush        (flush),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .alu_result   (alu_result),
      .alu_zero_flag(alu_zero_flag),
      .alu_illegal  (alu_illegal)
    );

    function automatic string nm(input string s);
      return $sformatf("w%0d %s", W, s);
    endfunction

    // Reference model: plain arithmetic on W-bit unsigned values.
    function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, output logic ill);
      logic [31:0]  bw;
      int unsigned  sh;
      logic [W-1:0] ones;
      bw   = 32'(b);
      sh   = bw % W;
      ones = '1;
      ill  = 1'b0;
      case (op)
        4'd0:  return a & b;
        4'd1:  return a | b;
        4'd2:  return a + b;
        4'd3:  return a ^ b;
        4'd4:  return a << sh;
        4'd5:  return a >> sh;
        4'd6:  return a - b;
        4'd7:  return (a >> sh) | (a[W-1] ? ~(ones >> sh) : '0);
        4'd8:  return ($signed(a) < $signed(b)) ? W'(1) : '0;
        4'd9:  return (a < b) ? W'(1) : '0;
        4'd10: return (b == '0) ? ones : a / b;
        4'd11: return (b == '0) ? a : a % b;
        default: begin
          ill = 1'b1;
          return '0;
        end
      endcase
    endfunction

    task automatic check_reset(input string tag);
      check(nm({tag, " out_valid"}), 64'(out_valid), 64'd0);
      check(nm({tag, " result"}), 64'(alu_result), 64'd0);
      check(nm({tag, " zero_flag"}), 64'(alu_zero_flag), 64'd1);
      check(nm({tag, " illegal"}), 64'(alu_illegal), 64'd0);
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit push, input bit use_exp, input logic [W-1:0] exp_r,
                        input logic exp_ill, input bit rbp);
      int           n;
      logic [W-1:0] r;
      logic         ill;
      exp_t         it;
      n = 0;
      while (!in_ready && n < 500) begin
        @(negedge clk);
        if (rbp) out_ready = ($urandom_range(0, 3) != 0);
        n++;
      end
      if (!in_ready) begin
        fail_now(nm("in_ready timeout"));
        return;
      end
      alu_control = op;
      operand_a   = a;
      operand_b   = b;
      in_valid    = 1'b1;
      if (push) begin
        r = model(op, a, b, ill);
        if (use_exp) begin
          r   = exp_r;
          ill = exp_ill;
        end
        it.result     = 64'(r);
        it.illegal    = ill;
        it.accept_cyc = cyc + 1;
        it.latency    = (op == 4'd10 || op == 4'd11) ? W + 1 : 1;
        sb_q.push_back(it);
      end
      @(negedge clk);
      in_valid    = 1'b0;
      alu_control = 4'($urandom);
      operand_a   = W'($urandom);
      operand_b   = W'($urandom);
    endtask

    task automatic wait_idle();
      int n;
      n = 0;
      while (!in_ready && n < 500) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready) fail_now(nm("idle timeout"));
    endtask

    // Monitor: pops one expectation per presented result, then checks it stays held.
    initial begin
      bit   pending;
      exp_t it;
      pending = 0;
      forever begin
        @(negedge clk);
        if (!rst_n || !out_valid) begin
          pending = 0;
        end else if (!pending) begin
          pending = 1;
          if (sb_q.size() == 0) begin
            fail_now(nm("unexpected out_valid"));
            it.result  = 64'(alu_result);
            it.illegal = alu_illegal;
          end else begin
            it = sb_q.pop_front();
            check(nm("result"), 64'(alu_result), it.result);
            check(nm("zero_flag"), 64'(alu_zero_flag), 64'(it.result == 64'd0));
            check(nm("illegal"), 64'(alu_illegal), 64'(it.illegal));
            check(nm("latency"), 64'(cyc - it.accept_cyc + 1), 64'(it.latency));
          end
        end else begin
          check(nm("held result"), 64'(alu_result), it.result);
        end
      end
    end

    initial begin
      logic [W-1:0] ha, hb, hexp;
      logic         hill;
      int           n;
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      flush       = 1'b0;
      out_ready   = 1'b1;
      operand_a   = '0;
      operand_b   = '0;
      alu_control = '0;
      #1;
      check_reset("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1 check(nm("in_ready after reset"), 64'(in_ready), 64'd1);
      @(negedge clk);

      // Directed boundary cases with literal expectations.
      send(4'd2, '1, W'(1), 1, 1, '0, 1'b0, 0);
      send(4'd7, W'(1) << (W - 1), W'(W + 4), 1, 1,
           (W == 32) ? W'(32'hF800_0000) : W'(8'hF8), 1'b0, 0);
      send(4'd8, '1, W'(1), 1, 1, W'(1), 1'b0, 0);
      send(4'd9, '1, W'(1), 1, 1, '0, 1'b0, 0);
      send(4'd10, W'(100), W'(7), 1, 1, W'(14), 1'b0, 0);
      send(4'd11, W'(100), W'(7), 1, 1, W'(2), 1'b0, 0);
      send(4'd10, W'(200), W'(3), 1, 1, W'(66), 1'b0, 0);
      send(4'd11, W'(200), W'(3), 1, 1, W'(2), 1'b0, 0);
      send(4'd10, W'(5), '0, 1, 1, '1, 1'b0, 0);
      send(4'd11, W'(5), '0, 1, 1, W'(5), 1'b0, 0);
      wait_idle();

      // Backpressure: result held for 5 cycles, then released.
      out_ready = 1'b0;
      ha   = W'($urandom);
      hb   = W'($urandom);
      hexp = model(4'd2, ha, hb, hill);
      send(4'd2, ha, hb, 1, 0, '0, 1'b0, 0);
      n = 0;
      while (!out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!out_valid) fail_now(nm("hold out_valid"));
      repeat (5) begin
        @(negedge clk);
        operand_a = W'($urandom);
        check(nm("hold out_valid"), 64'(out_valid), 64'd1);
        check(nm("hold in_ready"), 64'(in_ready), 64'd0);
        check(nm("hold value"), 64'(alu_result), 64'(hexp));
      end
      out_ready = 1'b1;
      @(negedge clk);
      check(nm("release in_ready"), 64'(in_ready), 64'd1);
      check(nm("release out_valid"), 64'(out_valid), 64'd0);

      // Reset asserted in the middle of a divide.
      send(4'd10, W'(200), W'(3), 0, 0, '0, 1'b0, 0);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1 check_reset("mid-div reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1 check(nm("in_ready after mid-div reset"), 64'(in_ready), 64'd1);
      repeat (W + 5) @(negedge clk);

      // Flush during BUSY, then an unsupported encoding.
      send(4'd11, W'(100), W'(7), 0, 0, '0, 1'b0, 0);
      repeat ((W == 32) ? 9 : 4) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check(nm("flush out_valid"), 64'(out_valid), 64'd0);
      check(nm("flush in_ready"), 64'(in_ready), 64'd1);
      repeat (W + 5) @(negedge clk);
      send(4'b1111, W'($urandom), W'($urandom), 1, 1, '0, 1'b1, 0);
      wait_idle();

      // Random operations with random backpressure.
      for (int i = 0; i < 80; i++) begin
        logic [3:0]   op;
        logic [W-1:0] a, b;
        op = 4'($urandom_range(0, 15));
        a  = W'($urandom);
        case ($urandom_range(0, 7))
          0:       b = '0;
          1, 2:    b = W'($urandom_range(1, 20));
          default: b = W'($urandom);
        endcase
        send(op, a, b, 1, 0, '0, 1'b0, 1);
      end
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      wait_idle();
      @(negedge clk);
      check(nm("scoreboard drained"), 64'(sb_q.size()), 64'd0);
      done_flag = 1;
    end
  end

  initial begin
    wait (env[0].done_flag && env[1].done_flag);
    if (!finished) begin
      finished = 1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
    end
  end

  initial begin
    #300000;
    if (!finished) begin
      finished = 1;
      fail_now("watchdog");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
    end
  end

endmodule
